imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Boot-time program loader. Receives a byte stream (16-bit big-endian word
//   count N followed by N big-endian 32-bit words) and writes each word into
//   the instruction memory at consecutive word addresses. The CPU fetch stage
//   is held in reset (cpu_rst=1) until a session completes successfully.
//
// Optional feature:
//   IMEM_LOADER_CHECKSUM_EN - when defined, a running XOR of every written
//   word is kept and a 4-byte big-endian trailer is expected after the last
//   word. A match ends in DONE, a mismatch in ERR. With N=0 the expected
//   trailer is 32'h00000000. When undefined, no trailer is consumed.
//
// Ports:
//   CLK        in   1  clock, rising edge
//   RST_N      in   1  synchronous active-low reset
//   start      in   1  begin a session (honoured only in IDLE/DONE/ERR)
//   rx_data    in   8  incoming program byte
//   rx_valid   in   1  rx_data valid
//   rx_ready   out  1  byte accepted when rx_valid && rx_ready on an edge
//   cpu_rst    out  1  hold for fetch stage / pipeline (low only in DONE)
//   imem_we    out  1  instruction memory write strobe (WRITE state only)
//   imem_addr  out 32  byte address of the word being written
//   imem_wdata out 32  word being written
//   busy       out  1  session in progress
//   done       out  1  program loaded, CPU released
//   err        out  1  session failed
//   word_cnt   out 16  words written in the current session
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int IMEM_SIZE = 64
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cpu_rst,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_cnt
);

    // One extra bit so N=65535 cannot wrap when compared to the depth.
    localparam logic [16:0] MAX_WORDS = 17'(IMEM_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q;
    logic [15:0] len_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] word_cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
    logic [31:0] chk_q;
`endif

    logic        accept;
    logic [15:0] len_full;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    // Complete length as it will look once the second LEN byte lands.
    assign len_full  = {len_q[15:8], rx_data};
    // True in WRITE when the word being written is the final one.
    assign last_word = (word_cnt_q + 16'd1) == len_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept && byte_cnt_q == 2'd1) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept && byte_cnt_q == 2'd3) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept && byte_cnt_q == 2'd3) begin
                    if ({chk_q[23:0], rx_data} == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are pure functions of the current state.
    // ------------------------------------------------------------------
    always_comb begin
        rx_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_rst  = 1'b1;
        case (state_q)
            ST_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            ST_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. The byte counter wraps naturally 3->0, so it is already
    // zero when DATA hands over to WRITE and when the trailer begins.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            byte_cnt_q <= 2'd0;
            len_q      <= 16'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            word_cnt_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= 32'd0;
            chk_q      <= 32'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        byte_cnt_q <= 2'd0;
                        len_q      <= 16'd0;
                        addr_q     <= 32'd0;
                        word_cnt_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q     <= 32'd0;
`endif
                    end
                end
                ST_LEN: begin
                    if (accept) begin
                        if (byte_cnt_q == 2'd0) begin
                            len_q[15:8] <= rx_data;
                            byte_cnt_q  <= 2'd1;
                        end else begin
                            len_q      <= len_full;
                            byte_cnt_q <= 2'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        wdata_q    <= {wdata_q[23:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                ST_WRITE: begin
                    addr_q     <= addr_q + 32'd4;
                    word_cnt_q <= word_cnt_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_q     <= csum_q ^ wdata_q;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        chk_q      <= {chk_q[23:0], rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed self-checking bench for imem_loader (IMEM_SIZE=64). Every write
// strobe is logged (one entry per cycle imem_we is high) so write counts,
// addresses and data can be checked after each session. Trailer bytes are
// sent only when IMEM_LOADER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cpu_rst;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always #5 CLK = ~CLK;

    imem_loader #(.IMEM_SIZE(64)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .cpu_rst    (cpu_rst),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_cnt   (word_cnt)
    );

    always @(posedge CLK) begin
        if (imem_we === 1'b1) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one byte and wait (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        assert (n < 20) else begin
            failures++;
            $error("FAIL send_timeout observed=%0d cycles expected=<20", n);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] xacc;
        logic [7:0]  seq2 [4];

        RST_N    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) tick();

        // Reset state
        chk1 ("rst_cpu_rst",  cpu_rst,  1'b1);
        chk1 ("rst_busy",     busy,     1'b0);
        chk1 ("rst_done",     done,     1'b0);
        chk1 ("rst_err",      err,      1'b0);
        chk1 ("rst_rx_ready", rx_ready, 1'b0);
        chk1 ("rst_imem_we",  imem_we,  1'b0);
        chk32("rst_addr",     imem_addr,  32'h0);
        chk32("rst_wdata",    imem_wdata, 32'h0);
        chk32("rst_word_cnt", {16'h0, word_cnt}, 32'h0);
        RST_N = 1'b1;
        tick();
        chk1("idle_busy", busy, 1'b0);
        $display("step reset: checks=%0d", checks);

        // Basic two-word load
        pulse_start();
        chk1("len_busy", busy, 1'b1);
        chk1("len_rx_ready", rx_ready, 1'b1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h20010005);
        chk1 ("w0_we", imem_we, 1'b1);
        chk1 ("w0_rx_ready", rx_ready, 1'b0);
        chk32("w0_addr", imem_addr, 32'h0);
        chk32("w0_wdata", imem_wdata, 32'h20010005);
        tick();
        chk1 ("w0_we_after", imem_we, 1'b0);
        chk32("w0_addr_inc", imem_addr, 32'h4);
        chk32("w0_cnt", {16'h0, word_cnt}, 32'd1);
        send_word(32'h8C020000);
        chk1 ("w1_we", imem_we, 1'b1);
        chk32("w1_addr", imem_addr, 32'h4);
        chk32("w1_wdata", imem_wdata, 32'h8C020000);
        tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hAC030005);
`endif
        chk1 ("basic_done", done, 1'b1);
        chk1 ("basic_cpu_rst", cpu_rst, 1'b0);
        chk1 ("basic_busy", busy, 1'b0);
        chk1 ("basic_rx_ready", rx_ready, 1'b0);
        chk32("basic_cnt", {16'h0, word_cnt}, 32'd2);
        chk32("basic_nwr", 32'(log_addr.size()), 32'd2);
        chk32("basic_a0", log_addr[0], 32'h0);
        chk32("basic_d0", log_data[0], 32'h20010005);
        chk32("basic_a1", log_addr[1], 32'h4);
        chk32("basic_d1", log_data[1], 32'h8C020000);
        $display("step basic load: checks=%0d failures=%0d", checks, failures);

        // Byte offered while not ready is left alone
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        repeat (3) tick();
        rx_valid = 1'b0;
        chk1 ("done_hold", done, 1'b1);
        chk32("done_hold_cnt", {16'h0, word_cnt}, 32'd2);

        // Start in DONE re-enters LEN
        pulse_start();
        chk1 ("restart_cpu_rst", cpu_rst, 1'b1);
        chk1 ("restart_busy", busy, 1'b1);
        chk1 ("restart_rx_ready", rx_ready, 1'b1);
        chk1 ("restart_done", done, 1'b0);
        chk32("restart_cnt", {16'h0, word_cnt}, 32'd0);
        chk32("restart_addr", imem_addr, 32'h0);
        $display("step restart from done: checks=%0d failures=%0d", checks, failures);

        // Oversized length 0x41 = 65 > 64
        send_byte(8'h00);
        send_byte(8'h41);
        chk1 ("ovr_err", err, 1'b1);
        chk1 ("ovr_cpu_rst", cpu_rst, 1'b1);
        chk1 ("ovr_rx_ready", rx_ready, 1'b0);
        chk1 ("ovr_busy", busy, 1'b0);
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        repeat (2) tick();
        rx_valid = 1'b0;
        chk1 ("ovr_err_hold", err, 1'b1);
        chk32("ovr_nwr", 32'(log_addr.size()), 32'd2);
        $display("step oversize: checks=%0d failures=%0d", checks, failures);

        // Start ignored in DATA; rx_valid toggling on the second word
        pulse_start();
        chk1("err_cleared", err, 1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'hCAFEBABE);
        chk1 ("tg_w0_we", imem_we, 1'b1);
        tick();
        pulse_start();
        chk1 ("tg_start_busy", busy, 1'b1);
        chk1 ("tg_start_ready", rx_ready, 1'b1);
        chk32("tg_start_cnt", {16'h0, word_cnt}, 32'd1);
        seq2[0] = 8'h12; seq2[1] = 8'h34; seq2[2] = 8'h56; seq2[3] = 8'h78;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) start = 1'b1;     // coincides with a byte accept
            send_byte(seq2[i]);
            start   = 1'b0;
            rx_data = 8'h5A;              // junk during the gap cycle
            tick();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hD8CAECC6);
`endif
        chk1 ("tg_done", done, 1'b1);
        chk32("tg_cnt", {16'h0, word_cnt}, 32'd2);
        chk32("tg_nwr", 32'(log_addr.size()), 32'd4);
        chk32("tg_a0", log_addr[2], 32'h0);
        chk32("tg_d0", log_data[2], 32'hCAFEBABE);
        chk32("tg_a1", log_addr[3], 32'h4);
        chk32("tg_d1", log_data[3], 32'h12345678);
        $display("step gap/start-in-data: checks=%0d failures=%0d", checks, failures);

        // Reset after two data bytes
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        RST_N = 1'b0;
        tick();
        chk1 ("mr_busy", busy, 1'b0);
        chk1 ("mr_cpu_rst", cpu_rst, 1'b1);
        chk1 ("mr_rx_ready", rx_ready, 1'b0);
        chk32("mr_wdata", imem_wdata, 32'h0);
        chk32("mr_cnt", {16'h0, word_cnt}, 32'd0);
        RST_N = 1'b1;
        repeat (3) tick();
        chk32("mr_nwr", 32'(log_addr.size()), 32'd4);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h11223344);
        tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h11223344);
`endif
        chk1 ("mr_fresh_done", done, 1'b1);
        chk32("mr_fresh_cnt", {16'h0, word_cnt}, 32'd1);
        chk32("mr_fresh_nwr", 32'(log_addr.size()), 32'd5);
        chk32("mr_fresh_a", log_addr[4], 32'h0);
        chk32("mr_fresh_d", log_data[4], 32'h11223344);
        $display("step mid-word reset: checks=%0d failures=%0d", checks, failures);

        // N = 0
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'h00000000);
`endif
        chk1 ("n0_done", done, 1'b1);
        chk1 ("n0_cpu_rst", cpu_rst, 1'b0);
        chk32("n0_cnt", {16'h0, word_cnt}, 32'd0);
        chk32("n0_nwr", 32'(log_addr.size()), 32'd5);
        $display("step zero length: checks=%0d failures=%0d", checks, failures);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailer off by one bit, then retry
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h01020304);
        tick();
        send_word(32'h01020305);
        chk1("ck_err", err, 1'b1);
        chk1("ck_cpu_rst", cpu_rst, 1'b1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h01020304);
        tick();
        send_word(32'h01020304);
        chk1 ("ck_retry_done", done, 1'b1);
        chk32("ck_nwr", 32'(log_addr.size()), 32'd7);
        $display("step checksum: checks=%0d failures=%0d", checks, failures);
`endif

        // Full-depth load, N = 64
        begin
            int base;
            base = log_addr.size();
            xacc = 32'h0;
            pulse_start();
            send_byte(8'h00);
            send_byte(8'h40);
            for (int i = 0; i < 64; i++) begin
                w = {8'(i), 8'hA5, 8'(255 - i), 8'(i * 3)};
                xacc = xacc ^ w;
                send_word(w);
                tick();
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_word(xacc);
`endif
            chk1 ("full_done", done, 1'b1);
            chk32("full_cnt", {16'h0, word_cnt}, 32'd64);
            chk32("full_nwr", 32'(log_addr.size() - base), 32'd64);
            for (int i = 0; i < 64; i++) begin
                w = {8'(i), 8'hA5, 8'(255 - i), 8'(i * 3)};
                chk32($sformatf("full_a%0d", i), log_addr[base + i], 32'(i * 4));
                chk32($sformatf("full_d%0d", i), log_data[base + i], w);
            end
            $display("step full depth: checks=%0d failures=%0d", checks, failures);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
